// File: rtl/fan_pkg.sv
// Shared definitions for the FAN result collector: default sizes,
// derived slot geometry and the collector FSM state encoding.
package fan_pkg;

    localparam int DW_DATA_DEF = 32;
    localparam int N_DEF       = 32;
    localparam int N_ADDERS    = N_DEF - 1;
    localparam int NSLOT       = 2 * N_ADDERS;
    localparam int IDX_W       = $clog2(NSLOT);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage : fan_pkg

// File: rtl/fan_prio_enc.sv
// Lowest-set-bit priority encoder over the slot mask. Also reports whether
// any bit is set and whether exactly one bit is set.
module fan_prio_enc #(
    parameter int W  = fan_pkg::NSLOT,
    parameter int IW = fan_pkg::IDX_W
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found,
    output logic          single
);

    // Scan from the top down so the last hit wins, leaving the lowest index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest bit leaves nothing.
    assign single = found && ((vec & (vec - W'(1))) == '0);

endmodule : fan_prio_enc

// File: rtl/fan_out_collector.sv
// Collects one FAN result frame (per-slot mask plus data bus) and serialises
// the valid partial sums as a stream of beats in ascending slot order.
// A new frame can be accepted on the same cycle the previous frame's last
// beat leaves, so back-to-back frames drain without a bubble.
module fan_out_collector
    import fan_pkg::*;
#(
    parameter  int DW_DATA  = DW_DATA_DEF,
    parameter  int N        = N_DEF,
    localparam int N_ADD    = N - 1,
    localparam int NSLOT_L  = 2 * N_ADD,
    localparam int IDX_W_L  = $clog2(NSLOT_L)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NSLOT_L-1:0]         in_mask,
    input  logic [DW_DATA*NSLOT_L-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW_DATA-1:0]         out_data,
    output logic [IDX_W_L-1:0]         out_idx,
    output logic                       out_last,
    output logic [15:0]                frame_cnt
);

    state_e                     state_q, state_d;
    logic [NSLOT_L-1:0]         mask_q, mask_d;
    logic [DW_DATA*NSLOT_L-1:0] data_q, data_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;

    logic [IDX_W_L-1:0] enc_idx;
    logic               enc_found;
    logic               enc_single;

    logic drain;
    logic beat;
    logic last_beat;
    logic accept;
    logic accept_empty;

    fan_prio_enc #(
        .W  (NSLOT_L),
        .IW (IDX_W_L)
    ) u_prio_enc (
        .vec    (mask_q),
        .idx    (enc_idx),
        .found  (enc_found),
        .single (enc_single)
    );

    assign drain        = (state_q == ST_DRAIN);
    assign beat         = drain && out_ready;
    assign last_beat    = beat && enc_single;
    assign accept       = in_valid && in_ready;
    assign accept_empty = accept && (in_mask == '0);

    // Output stream: everything reads zero outside DRAIN.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || last_beat;
        out_valid = drain;
        out_last  = drain && enc_single;
        out_idx   = drain ? enc_idx : '0;
        out_data  = drain ? data_q[int'(enc_idx)*DW_DATA +: DW_DATA] : '0;
    end

    assign frame_cnt = frame_cnt_q;

    // Next-state: FSM transitions, mask consumption, frame load and counting.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        data_d      = data_q;
        frame_cnt_d = frame_cnt_q;

        if (beat) begin
            mask_d = mask_q & ~(NSLOT_L'(1) << enc_idx);
        end

        // A drained frame and an accepted empty frame can both complete in
        // the same cycle, so the counter may advance by two.
        frame_cnt_d = frame_cnt_q + 16'(last_beat) + 16'(accept_empty);

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d = (in_mask != '0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (last_beat) begin
                    if (accept) begin
                        state_d = (in_mask != '0) ? ST_DRAIN : ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (accept) begin
            mask_d = in_mask;
            data_d = in_data;
        end
    end

    // State and frame registers; reset discards any pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            mask_q      <= '0;
            data_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule : fan_out_collector

// File: tb/tb_fan_out_collector.sv
// Scoreboard bench for fan_out_collector: directed frames push their
// expected beats into a queue; a monitor pops and compares on each transfer.
module tb_fan_out_collector;

    localparam int DW    = 32;
    localparam int NL    = 32;
    localparam int NS    = 2 * (NL - 1);
    localparam int IW    = $clog2(NS);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NS-1:0]     in_mask;
    logic [DW*NS-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic [15:0]       frame_cnt;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [DW*NS-1:0]  frame_data;

    fan_out_collector #(.DW_DATA(DW), .N(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_beat(input int idx, input bit last);
        beat_t b;
        b.idx  = IW'(idx);
        b.data = DW'(idx + 100);
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Present a frame, wait for the accept edge, then confirm first-beat latency.
    task automatic send_frame(input logic [NS-1:0] m);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_mask  = m;
        in_data  = frame_data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready never rose, expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mask  = '0;
        if (m != '0) begin
            @(negedge clk);
            check("first_beat_latency", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1'b0 | 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor: scoreboard pops on every transfer; stalled beats must hold.
    initial begin : monitor
        beat_t held;
        beat_t got;
        beat_t want;
        bit    held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_v) begin
                    got = {out_idx, out_data, out_last};
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_hold", 64'(got), 64'(held));
                end
                if (out_valid && !out_ready) begin
                    held_v = 1'b1;
                    held   = {out_idx, out_data, out_last};
                end else begin
                    held_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    got = {out_idx, out_data, out_last};
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got idx %0d data %0d, expected none", out_idx, out_data);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", 64'(got), 64'(want));
                    end
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin : stim
        for (int k = 0; k < NS; k++) frame_data[k*DW +: DW] = DW'(k + 100);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset and INIT cycle.
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_out_bus", 64'({out_idx, out_data, out_last}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init_in_ready", 64'(in_ready), 64'd0);
        check("init_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_bus", 64'({out_valid, out_idx, out_data, out_last}), 64'd0);

        // Frame {1,5,61} with out_ready high throughout.
        @(posedge clk);
        #1;
        push_beat(1, 0); push_beat(5, 0); push_beat(61, 1);
        send_frame((NS'(1) << 1) | (NS'(1) << 5) | (NS'(1) << 61));
        wait_drain();
        check("frame_cnt_a", 64'(frame_cnt), 64'd1);

        // Same frame, stall 3 cycles on the second beat.
        @(posedge clk);
        #1;
        push_beat(1, 0); push_beat(5, 0); push_beat(61, 1);
        send_frame((NS'(1) << 1) | (NS'(1) << 5) | (NS'(1) << 61));
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_idx", 64'(out_idx), 64'd5);
        check("stall_data", 64'(out_data), 64'd105);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();
        check("frame_cnt_b", 64'(frame_cnt), 64'd2);

        // Back-to-back {0} then {2,3} with in_valid held high.
        @(posedge clk);
        #1;
        push_beat(0, 1);
        in_valid = 1'b1;
        in_mask  = NS'(1);
        in_data  = frame_data;
        @(negedge clk);
        check("b2b_idle_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        push_beat(2, 0); push_beat(3, 1);
        in_mask = (NS'(1) << 2) | (NS'(1) << 3);
        @(negedge clk);
        check("b2b_last_ready", 64'({out_valid, out_idx, out_last, in_ready}), 64'({1'b1, 6'd0, 1'b1, 1'b1}));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mask  = '0;
        @(negedge clk);
        check("b2b_no_bubble", 64'({out_valid, out_idx, in_ready}), 64'({1'b1, 6'd2, 1'b0}));
        wait_drain();
        check("frame_cnt_c", 64'(frame_cnt), 64'd4);

        // Empty frame: no beats, count advances, stays ready.
        @(posedge clk);
        #1;
        send_frame('0);
        repeat (3) begin
            @(negedge clk);
            check("empty_no_valid", 64'(out_valid), 64'd0);
        end
        check("empty_in_ready", 64'(in_ready), 64'd1);
        check("frame_cnt_d", 64'(frame_cnt), 64'd5);

        // Reset during the second beat of {4,9,20,33}.
        @(posedge clk);
        #1;
        push_beat(4, 0);
        send_frame((NS'(1) << 4) | (NS'(1) << 9) | (NS'(1) << 20) | (NS'(1) << 33));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_cnt", 64'(frame_cnt), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_cnt", 64'(frame_cnt), 64'd0);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        push_beat(7, 0); push_beat(8, 1);
        send_frame((NS'(1) << 7) | (NS'(1) << 8));
        wait_drain();
        check("frame_cnt_e", 64'(frame_cnt), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fan_out_collector
